// File: rtl/sram_mem.sv
// sram_mem: word-organised synchronous RAM with independent write and read
// channels, each using a valid/ready handshake with one outstanding transfer.
//
// Ports:
//   clock              rising-edge clock
//   reset              asynchronous active-low reset
//   wvalid/wready      write request handshake (waddr, wdata, wmask)
//   bvalid/bready      write response handshake, berr flags out-of-range
//   arvalid/arready    read request handshake (araddr, arsize)
//   rvalid/rready      read response handshake, rdata right-justified,
//                      rerr flags range, size or alignment errors
//
// Writes are byte-masked; the offset bits of waddr are ignored. Reads return
// the RAM content at the accept edge (write-first per byte when a write to the
// same word is accepted on that edge), delivered RD_LAT cycles later.
module sram_mem #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          RD_LAT    = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wvalid,
    output logic                wready,
    input  logic [31:0]         waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wmask,
    output logic                bvalid,
    input  logic                bready,
    output logic                berr,
    input  logic                arvalid,
    output logic                arready,
    input  logic [31:0]         araddr,
    input  logic [2:0]          arsize,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rerr
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [31:0] rel;
        rel = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((rel >> OFF) < 32'(DEPTH));
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] rel;
        rel = addr - BASE_ADDR;
        return rel[OFF +: AW];
    endfunction

    // Error if out of range, wider than a word, or misaligned for its size.
    function automatic logic rd_bad(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] amask;
        amask = (32'd1 << size) - 32'd1;
        return !addr_in_range(addr) || (int'(size) > OFF) || ((addr & amask) != 32'd0);
    endfunction

    // Shift the addressed lane down and keep only 2^size bytes.
    function automatic logic [DATA_W-1:0] fmt_rdata(input logic [DATA_W-1:0] word,
                                                    input logic [OFF-1:0]    off,
                                                    input logic [2:0]        size);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] msk;
        sh = word >> {off, 3'b000};
        for (int b = 0; b < NB; b++) begin
            msk[8*b +: 8] = (b < (1 << size)) ? 8'hFF : 8'h00;
        end
        return sh & msk;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wready_q, wready_d;
    logic              arready_q, arready_d;
    logic              bvalid_q, bvalid_d;
    logic              berr_q, berr_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              w_fire, w_ok, r_fire, r_err;
    logic [AW-1:0]     w_idx, r_idx;
    logic [DATA_W-1:0] r_word;

    assign w_fire = wvalid && wready_q;
    assign w_ok   = addr_in_range(waddr);
    assign w_idx  = word_idx(waddr);
    assign r_fire = arvalid && arready_q && (state_q == S_IDLE);
    assign r_err  = rd_bad(araddr, arsize);
    assign r_idx  = word_idx(araddr);

    // Storage has no reset; a write is only performed on its accept edge.
    always_ff @(posedge clock) begin
        if (w_fire && w_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) begin
                    mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Bypass bytes of a write accepted on the same edge (write-first).
    always_comb begin
        r_word = mem[r_idx];
        if (w_fire && w_ok && (w_idx == r_idx)) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) begin
                    r_word[8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bvalid_d = bvalid_q;
        berr_d   = berr_q;
        rvalid_d = rvalid_q;
        rerr_d   = rerr_q;
        rdata_d  = rdata_q;

        if (w_fire) begin
            bvalid_d = 1'b1;
            berr_d   = !w_ok;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
            berr_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (r_fire) begin
                    rerr_d  = r_err;
                    rdata_d = r_err ? '0 : fmt_rdata(r_word, araddr[OFF-1:0], arsize);
                    if (RD_LAT <= 1) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 3'(RD_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if (rready) begin
                    state_d  = S_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready flags are registered from next-state so they stay low in reset
        // and rise on the first edge after release.
        wready_d  = !bvalid_d;
        arready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            berr_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rerr_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            berr_q    <= berr_d;
            rvalid_q  <= rvalid_d;
            rerr_q    <= rerr_d;
            rdata_q   <= rdata_d;
        end
    end

    assign wready  = wready_q;
    assign arready = arready_q;
    assign bvalid  = bvalid_q;
    assign berr    = berr_q;
    assign rvalid  = rvalid_q;
    assign rerr    = rerr_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_sram_mem.sv
module tb_sram_mem;

    localparam int          DW     = 32;
    localparam int          DEPTH  = 1024;
    localparam int          RD_LAT = 3;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic          clock;
    logic          reset;
    logic          wvalid, wready, bvalid, bready, berr;
    logic [31:0]   waddr;
    logic [DW-1:0] wdata;
    logic [3:0]    wmask;
    logic          arvalid, arready, rvalid, rready, rerr;
    logic [31:0]   araddr;
    logic [2:0]    arsize;
    logic [DW-1:0] rdata;

    sram_mem #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .wvalid (wvalid),
        .wready (wready),
        .waddr  (waddr),
        .wdata  (wdata),
        .wmask  (wmask),
        .bvalid (bvalid),
        .bready (bready),
        .berr   (berr),
        .arvalid(arvalid),
        .arready(arready),
        .araddr (araddr),
        .arsize (arsize),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rerr   (rerr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Reference model: word store keyed by word index, plus response queues.
    logic [31:0] mdl [int];
    logic        exp_b [$];
    logic [32:0] exp_r [$];

    function automatic bit mdl_ok(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < 32'(DEPTH));
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int          idx;
        logic [31:0] w;
        if (mdl_ok(a)) begin
            idx = int'((a - BASE) / 4);
            w = mdl.exists(idx) ? mdl[idx] : 32'h0;
            for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
            mdl[idx] = w;
        end
    endtask

    function automatic logic [32:0] mdl_read(input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] w;
        int          idx;
        if (!mdl_ok(a) || sz > 3'd2 || (a % (32'd1 << sz)) != 0) return {1'b1, 32'h0};
        idx = int'((a - BASE) / 4);
        w = mdl.exists(idx) ? mdl[idx] : 32'h0;
        w = w >> (8 * (a % 4));
        if (sz == 3'd0) w = w & 32'h0000_00FF;
        else if (sz == 3'd1) w = w & 32'h0000_FFFF;
        return {1'b0, w};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return wready;
            1:       return bvalid;
            2:       return arready;
            3:       return rvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which);
        int t = 0;
        while (!sig(which) && t < 32) begin
            step();
            t++;
        end
        if (t == 32) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic take_b(input string tag);
        wait_for({tag, "_bvalid"}, 1);
        check({tag, "_berr"}, 32'(berr), 32'(exp_b.pop_front()));
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic take_r(input string tag, output logic [31:0] got);
        logic [32:0] e;
        wait_for({tag, "_rvalid"}, 3);
        e = exp_r.pop_front();
        check({tag, "_rdata"}, rdata, e[31:0]);
        check({tag, "_rerr"}, 32'(rerr), 32'(e[32]));
        got = rdata;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        waddr = a; wdata = d; wmask = m; wvalid = 1'b1;
        wait_for({tag, "_wready"}, 0);
        exp_b.push_back(!mdl_ok(a));
        mdl_write(a, d, m);
        step();
        wvalid = 1'b0;
        take_b(tag);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [2:0] sz, output logic [31:0] got);
        araddr = a; arsize = sz; arvalid = 1'b1;
        wait_for({tag, "_arready"}, 2);
        exp_r.push_back(mdl_read(a, sz));
        step();
        arvalid = 1'b0;
        take_r(tag, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, held;
        int          t, acc, nb, seen;

        reset = 1'b0;
        wvalid = 1'b0; waddr = '0; wdata = '0; wmask = '0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arsize = '0; rready = 1'b0;

        step();
        step();
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);

        reset = 1'b1;
        step();
        check("idle_wready",  32'(wready),  32'd1);
        check("idle_arready", 32'(arready), 32'd1);
        check("idle_bvalid",  32'(bvalid),  32'd0);
        check("idle_rvalid",  32'(rvalid),  32'd0);
        check("idle_rdata",   rdata,        32'd0);

        // Masked writes and size-aware reads.
        wr("w_full", 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111);
        wr("w_mask", 32'h8000_0010, 32'h0000_5500, 4'b0010);
        rd("r_word", 32'h8000_0010, 3'd2, got);
        check("plan_word", got, 32'hDEAD_55EF);
        rd("r_half", 32'h8000_0012, 3'd1, got);
        check("plan_half", got, 32'h0000_DEAD);
        rd("r_byte", 32'h8000_0011, 3'd0, got);
        check("plan_byte", got, 32'h0000_0055);
        rd("r_byte2", 32'h8000_0012, 3'd0, got);

        // Latency and hold under back-pressure.
        araddr = 32'h8000_0010; arsize = 3'd2; arvalid = 1'b1;
        wait_for("lat_arready", 2);
        exp_r.push_back(mdl_read(32'h8000_0010, 3'd2));
        step();
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 16) begin
            step();
            t++;
        end
        // Accept cycle N ends at the accept edge; rvalid first appears in N+3.
        check("rd_latency", 32'(t + 1), 32'(RD_LAT));
        held = rdata;
        for (int i = 0; i < 4; i++) begin
            check("hold_rvalid",  32'(rvalid),  32'd1);
            check("hold_rdata",   rdata,        held);
            check("hold_arready", 32'(arready), 32'd0);
            step();
        end
        take_r("lat", got);
        check("arready_back", 32'(arready), 32'd1);

        // Error responses.
        wr("w_last", BASE + 32'(4 * (DEPTH - 1)), 32'h5A5A_5A5A, 4'b1111);
        wr("w_low", 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'b1111);
        rd("r_low", 32'h7FFF_FFFC, 3'd2, got);
        rd("r_last", BASE + 32'(4 * (DEPTH - 1)), 3'd2, got);
        check("last_unchanged", got, 32'h5A5A_5A5A);
        rd("r_misal", 32'h8000_0011, 3'd1, got);
        rd("r_high", BASE + 32'(4 * DEPTH), 3'd2, got);
        rd("r_dword", 32'h8000_0010, 3'd3, got);

        // Same-edge write and read to one word.
        wr("w_zero", 32'h8000_0020, 32'h0000_0000, 4'b1111);
        waddr = 32'h8000_0020; wdata = 32'h1234_5678; wmask = 4'b1111; wvalid = 1'b1;
        araddr = 32'h8000_0020; arsize = 3'd2; arvalid = 1'b1;
        wait_for("col_wready", 0);
        wait_for("col_arready", 2);
        exp_b.push_back(1'b0);
        mdl_write(32'h8000_0020, 32'h1234_5678, 4'b1111);
        exp_r.push_back(mdl_read(32'h8000_0020, 3'd2));
        step();
        wvalid = 1'b0;
        arvalid = 1'b0;
        take_b("col");
        take_r("col", got);
        check("plan_collision", got, 32'h1234_5678);

        // Back-to-back writes with bready held high.
        waddr = 32'h8000_0030; wdata = 32'hCAFE_F00D; wmask = 4'b1111;
        wvalid = 1'b1; bready = 1'b1;
        acc = 0; nb = 0;
        for (int i = 0; i < 6; i++) begin
            if (bvalid) begin
                nb++;
                check("b2b_berr", 32'(berr), 32'(exp_b.pop_front()));
            end
            if (wvalid && wready) begin
                acc++;
                exp_b.push_back(1'b0);
                mdl_write(32'h8000_0030, 32'hCAFE_F00D, 4'b1111);
            end
            step();
        end
        wvalid = 1'b0; bready = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd3);
        check("b2b_resps", 32'(nb), 32'd3);
        rd("r_b2b", 32'h8000_0030, 3'd2, got);

        // Reset during a pending read response.
        araddr = 32'h8000_0010; arsize = 3'd2; arvalid = 1'b1;
        wait_for("rst_arready_w", 2);
        step();
        arvalid = 1'b0;
        wait_for("rst_rd", 3);
        step();
        reset = 1'b0;
        #1;
        check("abort_rvalid",  32'(rvalid),  32'd0);
        check("abort_arready", 32'(arready), 32'd0);
        check("abort_rdata",   rdata,        32'd0);
        step();
        step();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rvalid) seen++;
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        check("after_arready", 32'(arready), 32'd1);
        check("after_wready",  32'(wready),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_mem.md
Name: sram_mem

Overview:
- Parametrised on-chip successor to the DPI-backed Memory block: a synchronous word-organised RAM for NPC simulation and synthesis.
- Independent write and read channels, each with a valid/ready handshake and one outstanding transaction.
- Byte-masked writes; size-aware reads with configurable latency; address range and alignment checking with error responses.
- Sits between the LSU/IFU bus and the rest of the design.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8, power of two, 32 or 64.
- DEPTH, 1024, number of DATA_W words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LAT, 1, cycles from read accept to rvalid; legal range 1..4.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- wvalid  in  1  write request valid
- wready  out  1  write request accepted when high with wvalid
- waddr  in  32  byte address of write
- wdata  in  DATA_W  write data, lane-aligned to word
- wmask  in  DATA_W/8  byte enables, bit i enables wdata[8i+7:8i]
- bvalid  out  1  write response valid
- bready  in  1  write response consumed
- berr  out  1  write error (out of range), valid with bvalid
- arvalid  in  1  read request valid
- arready  out  1  read request accepted when high with arvalid
- araddr  in  32  byte address of read
- arsize  in  3  0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only)
- rvalid  out  1  read data valid
- rready  in  1  read data consumed
- rdata  out  DATA_W  read data, right-justified, zero-extended
- rerr  out  1  read error, valid with rvalid

Behaviour:
- Reset (reset=0, async): wready=0, arready=0, bvalid=0, berr=0, rvalid=0, rerr=0, rdata=0, read FSM=IDLE. RAM contents are not cleared.
- First cycle after release: wready=1, arready=1.
- Address decode:
  - OFF = log2(DATA_W/8); idx = (addr-BASE_ADDR)>>OFF.
  - In range iff addr>=BASE_ADDR and idx<DEPTH. Offset = addr[OFF-1:0].
- Write channel:
  - wready = !bvalid.
  - Handshake on wvalid&&wready.
  - If in range, each byte with wmask=1 is written at that clock edge; waddr offset bits are ignored.
  - bvalid rises the next cycle; berr = !in_range, and no write occurs when out of range.
  - bvalid/berr hold until bready=1, then clear. A new write may be accepted the cycle after bvalid clears.
- Read FSM:
  - IDLE: arready=1. On arvalid, capture the word at idx, the offset and arsize, then go to WAIT (RD_LAT>1) or RESP (RD_LAT=1).
  - WAIT: arready=0. Counter loads RD_LAT-1 at accept and decrements; go to RESP when it reaches 1.
  - RESP: rvalid=1, arready=0. On rready, go to IDLE; arready returns the following cycle.
- Read data:
  - rdata = (word >> 8*offset) masked to 2^arsize bytes; upper bits are zero.
  - rdata and rerr stay stable while rvalid && !rready.
- Read errors: rerr=1 and rdata=0 if any of the following holds:
  - address out of range;
  - arsize > OFF;
  - address not aligned to 2^arsize.
- Ordering:
  - Read data is the RAM content at the accept edge.
  - Same-cycle write and read accept to the same word: the read returns post-write data (write-first, per byte).
  - Writes after the read accept do not affect the pending read.
- The write and read channels operate fully concurrently; neither blocks the other.
- Reset asserted mid-transaction aborts the transaction: no response is issued, and a write not yet at its accept edge is not performed.

Test Plan:
- Reset then idle: after release, wready=1, arready=1, bvalid=0, rvalid=0, rdata=0.
- Masked write, then size reads:
  - Write 0x8000_0010, wdata=0xDEADBEEF, wmask=4'b1111, then wmask=4'b0010 with wdata=0x0000_5500. berr=0 on both.
  - Read 0x8000_0010 word -> 0xDEAD55EF; half at 0x8000_0012 -> 0x0000DEAD; byte at 0x8000_0011 -> 0x00000055.
- Latency: RD_LAT=3, read accepted at cycle N -> rvalid first high at N+3; hold rready=0 for 4 cycles -> rdata stable and arready=0 throughout.
- Errors:
  - Write to 0x7FFF_FFFC -> berr=1, and memory is unchanged (a read of that location also errors).
  - Half read at 0x8000_0011 -> rerr=1, rdata=0.
  - Word read at BASE_ADDR+4*DEPTH -> rerr=1.
- Collision: same-cycle write of 0x12345678 (mask 4'b1111) and read of 0x8000_0020 (prior 0) -> rdata=0x12345678.
- Concurrency and reset: back-to-back writes with bready=1 give one write per 2 cycles. A reads with rready=0 during which reset is pulsed low gives rvalid=0 immediately and no response afterwards.
